// File: rtl/ssd_scan_driver_if.sv
// Datapath-to-display bundle for the multiplexed seven-segment scan driver.
// The datapath side (master) presents digit codes and a load strobe; the driver (slave) owns the pins.
interface ssd_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  pending;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output load, value, dp_in,
    input  pending, seg, dp, an, frame_tick
  );

  modport slave (
    input  load, value, dp_in,
    output pending, seg, dp, an, frame_tick
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed DIGITS-digit seven-segment driver with a tear-free shadow/display
// register pair, optional hex glyphs, leading-zero blanking and selectable pin polarity.
module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit HEX_EN      = 1'b0,
  parameter bit BLANK_LZ    = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  ssd_scan_driver_if.slave   bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int VAL_W = 4 * DIGITS;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [6:0]        SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_POL   = {DIGITS{ACTIVE_LOW}};

  // Scan position
  logic [DIV_W-1:0]  div_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wrap_q;

  // Shadow captures loads at any time; display only changes at a frame wrap
  logic [VAL_W-1:0]  shadow_val_q;
  logic [DIGITS-1:0] shadow_dp_q;
  logic [VAL_W-1:0]  disp_val_q;
  logic [DIGITS-1:0] disp_dp_q;
  logic              pending_q;

  // Registered pin drivers
  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;
  logic              tick_q;

  logic              terminal;
  logic              wrap;
  logic [IDX_W-1:0]  idx_next;
  logic [3:0]        code;
  logic [DIGITS-1:0] blank;
  logic              zero_run;
  logic [6:0]        seg_next;
  logic              dp_next;
  logic [DIGITS-1:0] an_next;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'h0:    g = 7'b1111110;
      4'h1:    g = 7'b0110000;
      4'h2:    g = 7'b1101101;
      4'h3:    g = 7'b1111001;
      4'h4:    g = 7'b0110011;
      4'h5:    g = 7'b1011011;
      4'h6:    g = 7'b1011111;
      4'h7:    g = 7'b1110000;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1111011;
      4'hA:    g = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'hB:    g = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'hC:    g = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'hD:    g = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'hE:    g = HEX_EN ? 7'b1001111 : 7'b0000000;
      default: g = HEX_EN ? 7'b1000111 : 7'b0000000;
    endcase
    return g;
  endfunction

  // With DIGITS=1, IDX_LAST is 0, so every terminal count is also a wrap.
  always_comb begin
    terminal = (div_q == DIV_LAST);
    wrap     = terminal && (idx_q == IDX_LAST);
    idx_next = idx_q;
    if (wrap)          idx_next = '0;
    else if (terminal) idx_next = idx_q + 1'b1;
  end

  // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_val_q[4*i +: 4] == 4'd0);
      blank[i] = BLANK_LZ && zero_run && (i != 0);
    end
  end

  always_comb begin
    code     = disp_val_q[{idx_q, 2'b00} +: 4];
    seg_next = blank[idx_q] ? 7'b0000000 : decode(code);
    dp_next  = disp_dp_q[idx_q];
    an_next  = DIGITS'(1) << idx_q;
  end

  // NOTE: shadow and display are reset too, so a reset mid-frame discards any queued value.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_POL;
      dp_q         <= ACTIVE_LOW;
      an_q         <= AN_POL;
      tick_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let the display take the old shadow while a same-cycle load refills it.
      div_q  <= terminal ? '0 : div_q + 1'b1;
      idx_q  <= idx_next;
      wrap_q <= wrap;

      if (wrap && pending_q) begin
        disp_val_q <= shadow_val_q;
        disp_dp_q  <= shadow_dp_q;
      end

      if (bus.load) begin
        shadow_val_q <= bus.value;
        shadow_dp_q  <= bus.dp_in;
        pending_q    <= 1'b1;
      end else if (wrap) begin
        pending_q    <= 1'b0;
      end

      // Pins follow idx one cycle late; the tick marks the cycle digit 0 re-enables.
      seg_q  <= seg_next ^ SEG_POL;
      dp_q   <= dp_next ^ ACTIVE_LOW;
      an_q   <= an_next ^ AN_POL;
      tick_q <= wrap_q;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: two instances (decimal/active-high and hex/active-low) share stimulus
// and are compared every cycle against a frame-arithmetic model, plus hand-computed glyph checks.
module tb_ssd_scan_driver;
  localparam int D  = 4;
  localparam int RD = 4;
  localparam int F  = D * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ssd_scan_driver_if #(.DIGITS(D)) bus_a ();
  ssd_scan_driver_if #(.DIGITS(D)) bus_b ();

  assign bus_a.load  = load;
  assign bus_a.value = value;
  assign bus_a.dp_in = dp_in;
  assign bus_b.load  = load;
  assign bus_b.value = value;
  assign bus_b.dp_in = dp_in;

  ssd_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .HEX_EN(1'b0), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  ssd_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .HEX_EN(1'b1), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec glyph table, active-high
  function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex);
    logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    if (!hex && c > 4'd9) return 7'b0000000;
    return tbl[c];
  endfunction

  // Digit shown after post-reset edge k is (k/RD)%D; blanking looks at the value above that digit.
  function automatic logic [6:0] model_seg(input logic [15:0] disp, input int k,
                                           input bit hex, input bit lz_en);
    int         digit;
    logic [3:0] c;
    digit = (k / RD) % D;
    c     = disp[4*digit +: 4];
    if (lz_en && digit > 0 && (disp >> (4*digit)) == 16'd0) return 7'b0000000;
    return glyph(c, hex);
  endfunction

  // Model state: post-reset edge count, shadow/display contents, pending
  int          k = 0;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;
  bit          model_valid = 1'b0;

  logic [6:0]  exp_seg_a, exp_seg_b;
  logic        exp_dp_a, exp_dp_b, exp_tick, exp_pend;
  logic [3:0]  exp_an_a, exp_an_b;

  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (rst) begin
      k         <= 0;
      m_shadow  <= '0;
      m_disp    <= '0;
      m_sdp     <= '0;
      m_ddp     <= '0;
      m_pend    <= 1'b0;
      exp_pend  <= 1'b0;
      exp_seg_a <= 7'h00;
      exp_dp_a  <= 1'b0;
      exp_an_a  <= 4'h0;
      exp_seg_b <= 7'h7f;
      exp_dp_b  <= 1'b1;
      exp_an_b  <= 4'hf;
      exp_tick  <= 1'b0;
    end else begin
      exp_seg_a <= model_seg(m_disp, k, 1'b0, 1'b1);
      exp_seg_b <= ~model_seg(m_disp, k, 1'b1, 1'b0);
      exp_dp_a  <= m_ddp[(k / RD) % D];
      exp_dp_b  <= ~m_ddp[(k / RD) % D];
      exp_an_a  <= 4'b0001 << ((k / RD) % D);
      exp_an_b  <= ~(4'b0001 << ((k / RD) % D));
      exp_tick  <= (k > 0) && (k % F == 0);
      if ((k % F == F - 1) && m_pend) begin
        m_disp <= m_shadow;
        m_ddp  <= m_sdp;
      end
      if (load) begin
        m_shadow <= value;
        m_sdp    <= dp_in;
      end
      m_pend   <= load ? 1'b1 : ((k % F == F - 1) ? 1'b0 : m_pend);
      exp_pend <= load ? 1'b1 : ((k % F == F - 1) ? 1'b0 : m_pend);
      k        <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("a_seg",     bus_a.seg,        exp_seg_a);
      check("a_dp",      bus_a.dp,         exp_dp_a);
      check("a_an",      bus_a.an,         exp_an_a);
      check("a_tick",    bus_a.frame_tick, exp_tick);
      check("a_pending", bus_a.pending,    exp_pend);
      check("b_seg",     bus_b.seg,        exp_seg_b);
      check("b_dp",      bus_b.dp,         exp_dp_b);
      check("b_an",      bus_b.an,         exp_an_b);
      check("b_tick",    bus_b.frame_tick, exp_tick);
      check("b_pending", bus_b.pending,    exp_pend);
    end
  end

  // Park at the negedge following post-reset edge j
  task automatic at_edge(input int j);
    for (int n = 0; n < 400 && k != j + 1; n++) @(negedge clk);
    if (k != j + 1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL at_edge_timeout: reached edge %0d, wanted %0d", k - 1, j);
    end
  endtask

  // Present a load so that it is sampled by post-reset edge j
  task automatic do_load(input int j, input logic [15:0] v, input logic [3:0] d);
    at_edge(j - 1);
    load  = 1'b1;
    value = v;
    dp_in = d;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    dp_in = '0;
    repeat (3) @(negedge clk);
    check("rst_a_an",  bus_a.an,  4'b0000);
    check("rst_a_seg", bus_a.seg, 7'b0000000);
    check("rst_b_an",  bus_b.an,  4'b1111);
    check("rst_b_seg", bus_b.seg, 7'b1111111);
    check("rst_b_dp",  bus_b.dp,  1'b1);
    rst = 1'b0;

    // Post-reset scan of an all-zero display
    at_edge(0);
    check("start_an",   bus_a.an,         4'b0001);
    check("start_seg",  bus_a.seg,        7'b1111110);
    check("start_tick", bus_a.frame_tick, 1'b0);
    at_edge(3);
    check("dig0_hold",  bus_a.an,         4'b0001);
    at_edge(4);
    check("dig1_an",    bus_a.an,         4'b0010);
    check("dig1_blank", bus_a.seg,        7'b0000000);
    check("dig1_b_nolz", bus_b.seg,       7'b0000001);
    at_edge(15);
    check("dig3_an",    bus_a.an,         4'b1000);
    at_edge(16);
    check("frame_tick", bus_a.frame_tick, 1'b1);
    check("frame_an",   bus_a.an,         4'b0001);

    // Tear-free load of 1209 with dp on digit 2
    do_load(20, 16'h1209, 4'b0100);
    check("load_pend",  bus_a.pending,    1'b1);
    at_edge(25);
    check("old_dig2_seg", bus_a.seg,      7'b0000000);
    check("old_dig2_dp",  bus_a.dp,       1'b0);
    at_edge(31);
    check("pend_fall",  bus_a.pending,    1'b0);
    at_edge(32);
    check("new_dig0",   bus_a.seg,        7'b1111011);
    check("new_dig0_b", bus_b.seg,        7'b0000100);
    check("new_an_b",   bus_b.an,         4'b1110);
    at_edge(36);
    check("new_dig1",   bus_a.seg,        7'b1111110);
    at_edge(40);
    check("new_dig2",   bus_a.seg,        7'b1101101);
    check("new_dp2",    bus_a.dp,         1'b1);
    at_edge(44);
    check("new_dig3",   bus_a.seg,        7'b0110000);

    // Last load in a frame wins
    do_load(50, 16'h0005, 4'b0000);
    do_load(55, 16'h0007, 4'b0000);
    at_edge(64);
    check("last_wins",  bus_a.seg,        7'b1110000);
    at_edge(68);
    check("lz_blank",   bus_a.seg,        7'b0000000);

    // Load coinciding with the wrap edge
    do_load(70, 16'h0003, 4'b0000);
    do_load(79, 16'h0004, 4'b0000);
    check("coinc_pend", bus_a.pending,    1'b1);
    at_edge(80);
    check("coinc_old",  bus_a.seg,        7'b1111001);
    check("coinc_pend2", bus_a.pending,   1'b1);
    at_edge(95);
    check("coinc_fall", bus_a.pending,    1'b0);
    at_edge(96);
    check("coinc_new",  bus_a.seg,        7'b0110011);

    // Hex glyphs vs blanked codes, and pin inversion
    do_load(100, 16'hABCF, 4'b0000);
    at_edge(112);
    check("hex_off_F",  bus_a.seg,        7'b0000000);
    check("hex_F_inv",  bus_b.seg,        7'b0111000);
    check("dp_inv",     bus_b.dp,         1'b1);
    at_edge(116);
    check("hex_C_inv",  bus_b.seg,        7'b0110001);
    at_edge(120);
    check("hex_b_inv",  bus_b.seg,        7'b1100000);
    at_edge(124);
    check("hex_A_inv",  bus_b.seg,        7'b0001000);
    check("an3_inv",    bus_b.an,         4'b0111);
    check("hex_off_A",  bus_a.seg,        7'b0000000);

    // Reset mid-frame with a value pending
    do_load(130, 16'h0008, 4'b0001);
    at_edge(133);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_pend",  bus_a.pending,    1'b0);
    check("mrst_an",    bus_a.an,         4'b0000);
    check("mrst_seg",   bus_a.seg,        7'b0000000);
    @(negedge clk);
    rst = 1'b0;
    at_edge(0);
    check("mrst_start", bus_a.seg,        7'b1111110);
    check("mrst_an0",   bus_a.an,         4'b0001);
    at_edge(16);
    check("mrst_nofrm", bus_a.seg,        7'b1111110);
    check("mrst_dp",    bus_a.dp,         1'b0);
    at_edge(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
